// File: rtl/apb_master.sv
// APB initiator: decodes a CPU load/store onto one-hot PSEL and runs SETUP/ACCESS.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles with err=1.
module apb_master #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  input  logic [32*NUM_SLAVES-1:0] PRDATA_bus,
  input  logic [NUM_SLAVES-1:0]    PREADY_vec
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_selDecode;
  logic                  w_slvReady;
  logic [31:0]           w_slvRdata;
  logic                  w_timeout;
  logic [31:0]           w_rdata;
  logic                  w_ready;
  logic                  w_err;
  logic [31:0]           w_paddr;
  logic                  w_pwrite;
  logic [31:0]           w_pwdata;
  logic [NUM_SLAVES-1:0] w_psel;
  logic                  w_penable;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_badNumSlaves
    $error("apb_master: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 2");
  end

  // PSEL is one-hot during SETUP/ACCESS, so it doubles as the slave-return mux select.
  always_comb begin
    w_hit       = (addr[31:16] == BASE_ADDR[31:16]) && (32'(addr[15:12]) < NUM_SLAVES);
    w_selDecode = '0;
    w_slvRdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_selDecode[i] = (addr[15:12] == 4'(i));
      if (PSEL[i]) w_slvRdata = PRDATA_bus[32*i +: 32];
    end
    w_slvReady = |(PREADY_vec & PSEL);
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) + 1 > 5) ? $clog2(TIMEOUT_CYCLES) + 1 : 5;

  logic [CW-1:0] r_accessCnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                            r_accessCnt <= '0;
    else if (r_state == SETUP)             r_accessCnt <= '0;
    else if (r_state == ACCESS && !w_slvReady) r_accessCnt <= r_accessCnt + CW'(1);
  end

  assign w_timeout = (r_state == ACCESS) && (r_accessCnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
    end else begin
      r_state <= w_nextState;
      rdata   <= w_rdata;
      ready   <= w_ready;
      err     <= w_err;
      PADDR   <= w_paddr;
      PWRITE  <= w_pwrite;
      PWDATA  <= w_pwdata;
      PSEL    <= w_psel;
      PENABLE <= w_penable;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (transfer && w_hit) w_nextState = SETUP;
      SETUP:   w_nextState = ACCESS;
      ACCESS:  if (w_slvReady || w_timeout) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A PREADY arriving on the limit cycle takes priority over the timeout abort.
  always_comb begin
    w_rdata   = rdata;
    w_ready   = 1'b0;
    w_err     = 1'b0;
    w_paddr   = PADDR;
    w_pwrite  = PWRITE;
    w_pwdata  = PWDATA;
    w_psel    = PSEL;
    w_penable = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_psel = '0;
        if (transfer && w_hit) begin
          w_paddr  = addr;
          w_pwrite = write;
          w_pwdata = wdata;
          w_psel   = w_selDecode;
        end else if (transfer) begin
          w_ready = 1'b1;
          w_err   = 1'b1;
          w_rdata = '0;
        end
      end
      SETUP: w_penable = 1'b1;
      ACCESS: begin
        w_penable = 1'b1;
        if (w_slvReady) begin
          w_psel    = '0;
          w_penable = 1'b0;
          w_ready   = 1'b1;
          if (!PWRITE) w_rdata = w_slvRdata;
        end else if (w_timeout) begin
          w_psel    = '0;
          w_penable = 1'b0;
          w_ready   = 1'b1;
          w_err     = 1'b1;
          w_rdata   = '0;
        end
      end
      default: w_psel = '0;
    endcase
  end

endmodule
